// File: rtl/timer_unit_presc_multi.sv
`default_nettype none
// ============================================================================
// Module   : timer_unit_presc_multi
// Purpose  : NCH independent WIDTH-bit prescaler channels sharing one
//            reference-tick qualifier. Each channel has a programmable
//            terminal value, continuous or one-shot mode, a counter preload
//            and a synchronous clear.
// Ports    : clk_i, rst_i (async, active-high)
//            ref_tick_i            shared count qualifier
//            enable_i/clear_i/oneshot_i/write_i   per-channel controls [NCH]
//            write_value_i/compare_i  packed per-channel values [NCH*WIDTH]
//            count_o               packed counter registers [NCH*WIDTH]
//            tick_o/done_o         per-channel terminal pulse / sticky done
//            busy_o                any channel in RUN
// Revision : 1.0  initial release
// ============================================================================
module timer_unit_presc_multi #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ref_tick_i,
    input  logic [NCH-1:0]       enable_i,
    input  logic [NCH-1:0]       clear_i,
    input  logic [NCH-1:0]       oneshot_i,
    input  logic [NCH-1:0]       write_i,
    input  logic [NCH*WIDTH-1:0] write_value_i,
    input  logic [NCH*WIDTH-1:0] compare_i,
    output logic [NCH*WIDTH-1:0] count_o,
    output logic [NCH-1:0]       tick_o,
    output logic [NCH-1:0]       done_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [NCH-1:0] run_w;

    generate
        for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
            state_t           state_q, state_d;
            logic [WIDTH-1:0] count_q, count_d;
            logic             tick_q,  tick_d;
            logic             done_q,  done_d;
            logic [WIDTH-1:0] wval_w;
            logic [WIDTH-1:0] cmp_w;

            assign wval_w = write_value_i[ch*WIDTH +: WIDTH];
            assign cmp_w  = compare_i[ch*WIDTH +: WIDTH];

            // Priority: disable > clear > write > advance.
            always_comb begin
                state_d = state_q;
                count_d = count_q;
                tick_d  = 1'b0;
                done_d  = done_q;
                if (!enable_i[ch]) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    done_d  = 1'b0;
                end else if (clear_i[ch]) begin
                    state_d = ST_RUN;
                    count_d = '0;
                    done_d  = 1'b0;
                end else if (write_i[ch]) begin
                    // A preload never evaluates the terminal; a DONE channel
                    // only takes the new count and stays finished.
                    count_d = wval_w;
                    if (state_q == ST_IDLE) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    case (state_q)
                        ST_IDLE: state_d = ST_RUN;
                        ST_RUN: begin
                            if (ref_tick_i) begin
                                // >= rather than == so an overshoot from a
                                // preload or lowered compare still fires and
                                // count+1 can never wrap.
                                if (count_q >= cmp_w) begin
                                    tick_d  = 1'b1;
                                    count_d = '0;
                                    if (oneshot_i[ch]) begin
                                        state_d = ST_DONE;
                                        done_d  = 1'b1;
                                    end
                                end else begin
                                    count_d = count_q + C_ONE;
                                end
                            end
                        end
                        ST_DONE: state_d = ST_DONE;
                        default: state_d = ST_IDLE;
                    endcase
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    state_q <= ST_IDLE;
                    count_q <= '0;
                    tick_q  <= 1'b0;
                    done_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    count_q <= count_d;
                    tick_q  <= tick_d;
                    done_q  <= done_d;
                end
            end

            assign count_o[ch*WIDTH +: WIDTH] = count_q;
            assign tick_o[ch]                 = tick_q;
            assign done_o[ch]                 = done_q;
            assign run_w[ch]                  = (state_q == ST_RUN);
        end
    endgenerate

    assign busy_o = |run_w;

endmodule
`default_nettype wire

// File: tb/tb_timer_unit_presc_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_unit_presc_multi
// Purpose  : Directed self-checking bench for timer_unit_presc_multi
//            (WIDTH=8, NCH=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_timer_unit_presc_multi;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;

    logic                 clk;
    logic                 rst;
    logic                 ref_tick;
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       clr;
    logic [NCH-1:0]       os;
    logic [NCH-1:0]       wr;
    logic [NCH*WIDTH-1:0] wv;
    logic [NCH*WIDTH-1:0] cmp;
    wire  [NCH*WIDTH-1:0] count;
    wire  [NCH-1:0]       tick;
    wire  [NCH-1:0]       done;
    wire                  busy;

    int errors = 0;
    int checks = 0;

    timer_unit_presc_multi #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ref_tick_i   (ref_tick),
        .enable_i     (en),
        .clear_i      (clr),
        .oneshot_i    (os),
        .write_i      (wr),
        .write_value_i(wv),
        .compare_i    (cmp),
        .count_o      (count),
        .tick_o       (tick),
        .done_o       (done),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] cnt(input int ch);
        return count[ch*WIDTH +: WIDTH];
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ref_tick = 1'b1; en = '0; clr = '0; os = '0; wr = '0;
        wv = '0; cmp = '0;
        repeat (3) step();
        checks++;
        if (count !== '0 || tick !== '0 || done !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: count=%h tick=%b done=%b busy=%b want all 0", count, tick, done, busy);
        end
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if (count !== '0 || tick !== '0 || done !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_cycle%0d: count=%h tick=%b done=%b busy=%b want all 0", k, count, tick, done, busy);
            end
        end
    endtask

    task automatic test_continuous();
        int t[3];
        int nt;
        cmp[0*WIDTH +: WIDTH] = 8'd4;
        ref_tick = 1'b1;
        en[0] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            logic [WIDTH-1:0] ec;
            logic et;
            step();
            ec = (k == 1) ? 8'd0 : 8'((k - 1) % 5);
            et = (k > 1) && ((k - 1) % 5 == 0);
            checks++;
            if (cnt(0) !== ec || tick[0] !== et || busy !== 1'b1) begin
                errors++;
                $display("FAIL cont_k%0d: count=%0d tick=%b busy=%b want count=%0d tick=%b busy=1", k, cnt(0), tick[0], busy, ec, et);
            end
        end
        en[0] = 1'b0;
        step();
        checks++;
        if (cnt(0) !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cont_disable: count=%0d busy=%b want 0 0", cnt(0), busy);
        end
        // Half-rate reference: period becomes 10 clocks.
        en[0] = 1'b1;
        nt = 0;
        for (int k = 1; k <= 45; k++) begin
            ref_tick = k[0];
            step();
            if (tick[0] === 1'b1 && nt < 3) begin
                t[nt] = k;
                nt++;
            end
        end
        checks++;
        if (nt != 3 || (t[1] - t[0]) != 10 || (t[2] - t[1]) != 10) begin
            errors++;
            $display("FAIL cont_halfrate: pulses=%0d gaps=%0d,%0d want 3 pulses gaps 10,10", nt, t[1] - t[0], t[2] - t[1]);
        end
        en = '0;
        ref_tick = 1'b1;
        step();
    endtask

    task automatic test_oneshot();
        int nticks;
        int first;
        bit bad;
        nticks = 0; first = -1; bad = 0;
        cmp[1*WIDTH +: WIDTH] = 8'd2;
        os[1] = 1'b1;
        en[1] = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (tick[1] === 1'b1) begin
                nticks++;
                if (first < 0) first = k;
            end
            if (k >= 5 && (cnt(1) !== 8'd0 || done[1] !== 1'b1)) bad = 1;
        end
        checks++;
        if (nticks != 1 || first != 4) begin
            errors++;
            $display("FAIL oneshot_tick: pulses=%0d first=%0d want 1 at 4", nticks, first);
        end
        checks++;
        if (bad || done[1] !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_hold: done=%b count=%0d want done=1 count=0 held", done[1], cnt(1));
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_busy: busy=%b want 0", busy);
        end
        // Mode change alone does not restart a finished channel.
        os[1] = 1'b0;
        repeat (3) step();
        checks++;
        if (done[1] !== 1'b1 || cnt(1) !== 8'd0) begin
            errors++;
            $display("FAIL oneshot_modechg: done=%b count=%0d want 1 0", done[1], cnt(1));
        end
        os[1] = 1'b1;
        clr[1] = 1'b1;
        step();
        clr[1] = 1'b0;
        checks++;
        if (done[1] !== 1'b0 || busy !== 1'b1 || cnt(1) !== 8'd0) begin
            errors++;
            $display("FAIL oneshot_clear: done=%b busy=%b count=%0d want 0 1 0", done[1], busy, cnt(1));
        end
        step();
        checks++;
        if (cnt(1) !== 8'd1) begin
            errors++;
            $display("FAIL oneshot_resume: count=%0d want 1", cnt(1));
        end
        en = '0; os = '0;
        step();
    endtask

    task automatic test_priority();
        cmp[2*WIDTH +: WIDTH] = 8'd10;
        ref_tick = 1'b1;
        en[2] = 1'b1;
        step();
        wr[2] = 1'b1;
        wv[2*WIDTH +: WIDTH] = 8'd20;
        step();
        wr[2] = 1'b0;
        checks++;
        if (cnt(2) !== 8'd20 || tick[2] !== 1'b0) begin
            errors++;
            $display("FAIL prio_write: count=%0d tick=%b want 20 0", cnt(2), tick[2]);
        end
        step();
        checks++;
        if (cnt(2) !== 8'd0 || tick[2] !== 1'b1) begin
            errors++;
            $display("FAIL prio_overshoot: count=%0d tick=%b want 0 1", cnt(2), tick[2]);
        end
        repeat (3) step();
        checks++;
        if (cnt(2) !== 8'd3) begin
            errors++;
            $display("FAIL prio_count: count=%0d want 3", cnt(2));
        end
        clr[2] = 1'b1;
        wr[2]  = 1'b1;
        step();
        clr[2] = 1'b0;
        wr[2]  = 1'b0;
        checks++;
        if (cnt(2) !== 8'd0 || tick[2] !== 1'b0) begin
            errors++;
            $display("FAIL prio_clear_write: count=%0d tick=%b want 0 0", cnt(2), tick[2]);
        end
        en = '0;
        step();
    endtask

    task automatic test_boundary();
        cmp[3*WIDTH +: WIDTH] = 8'd255;
        ref_tick = 1'b1;
        en[3] = 1'b1;
        step();
        wr[3] = 1'b1;
        wv[3*WIDTH +: WIDTH] = 8'd254;
        step();
        wr[3] = 1'b0;
        checks++;
        if (cnt(3) !== 8'd254) begin
            errors++;
            $display("FAIL bound_preload: count=%0d want 254", cnt(3));
        end
        step();
        checks++;
        if (cnt(3) !== 8'd255 || tick[3] !== 1'b0) begin
            errors++;
            $display("FAIL bound_max: count=%0d tick=%b want 255 0", cnt(3), tick[3]);
        end
        step();
        checks++;
        if (cnt(3) !== 8'd0 || tick[3] !== 1'b1) begin
            errors++;
            $display("FAIL bound_wrap: count=%0d tick=%b want 0 1", cnt(3), tick[3]);
        end
        cmp[3*WIDTH +: WIDTH] = 8'd0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (tick[3] !== 1'b1 || cnt(3) !== 8'd0) begin
                errors++;
                $display("FAIL bound_cmp0_k%0d: tick=%b count=%0d want 1 0", k, tick[3], cnt(3));
            end
        end
        en = '0;
        step();
    endtask

    task automatic test_isolation();
        int cv[4];
        cv[0] = 1; cv[1] = 2; cv[2] = 3; cv[3] = 7;
        for (int ch = 0; ch < NCH; ch++) cmp[ch*WIDTH +: WIDTH] = 8'(cv[ch]);
        ref_tick = 1'b1;
        os = '0;
        en = 4'hF;
        for (int k = 1; k <= 24; k++) begin
            step();
            for (int ch = 0; ch < NCH; ch++) begin
                logic [WIDTH-1:0] ec;
                logic et;
                ec = (k == 1) ? 8'd0 : 8'((k - 1) % (cv[ch] + 1));
                et = (k > 1) && ((k - 1) % (cv[ch] + 1) == 0);
                checks++;
                if (cnt(ch) !== ec || tick[ch] !== et) begin
                    errors++;
                    $display("FAIL iso_ch%0d_k%0d: count=%0d tick=%b want %0d %b", ch, k, cnt(ch), tick[ch], ec, et);
                end
            end
        end
        // Reset asserted between edges must clear outputs without a clock.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (count !== '0 || tick !== '0 || done !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: count=%h tick=%b done=%b busy=%b want all 0", count, tick, done, busy);
        end
        step();
        rst = 1'b0;
        en = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_oneshot();
        test_priority();
        test_boundary();
        test_isolation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
